thread_pc_controller: RTL
=========================

Name: thread_pc_controller

Overview:
- Per-thread program counter sequencer. It sits directly downstream of the array of branch-check instances.
- Each cycle it OR-reduces their per-instance branch_destination/jump outputs and applies I/O-ready re-issue.
- It updates the PC of the thread in the current round-robin slot and issues that PC to instruction fetch.
- It holds all thread PCs internally as a register array.

Parameters:
PC_WIDTH, 10, width of a program counter
THREAD_COUNT, 8, number of round-robin threads (>=2)
THREAD_ADDR_WIDTH, 3, clog2(THREAD_COUNT)
BRANCH_COUNT, 4, number of branch-check instances feeding this block
INITIAL_THREAD, 0, thread slot served in the first cycle after reset
START_PC, 0, PC every thread issues on its first slot after reset

Ports:
clock  in  1  system clock
reset  in  1  reset; asynchronous, active-high
branch_destination_bus  in  BRANCH_COUNT*PC_WIDTH  concatenated per-instance destinations; instance i at [i*PC_WIDTH +: PC_WIDTH]
jump_bus  in  BRANCH_COUNT  per-instance jump decisions
IO_ready  in  1  previous instruction of the current-slot thread completed its I/O (low = annulled, must re-issue)
pc  out  PC_WIDTH  issued PC, registered
pc_thread  out  THREAD_ADDR_WIDTH  thread owning pc, registered
pc_valid  out  1  pc is a real issue, registered

Behaviour:
- Slot counter `slot`:
  - Reset to INITIAL_THREAD.
  - Increments every cycle; wraps THREAD_COUNT-1 -> 0.
  - Never stalls.
- Per-thread state:
  - pc_mem[t] (PC_WIDTH) holds the last issued PC of thread t.
  - started[t] (1 bit).
  - Reset: pc_mem[*]=START_PC, started[*]=0.
- Input alignment: jump_bus, branch_destination_bus and IO_ready sampled in a cycle belong to the instruction issued for thread `slot` THREAD_COUNT cycles earlier. Upstream guarantees this alignment.
- Reduction:
  - jump_any = OR(jump_bus).
  - dest_any = bitwise OR of all destination slices.
  - Non-jumping instances drive zero destination by contract. If several jump, dest_any is the OR of their destinations; no error is flagged.
- next-PC selection for thread t=slot, priority order:
  1. started[t]==0 -> next=START_PC, started[t]<=1; inputs ignored.
  2. IO_ready==0 -> next=pc_mem[t] (re-issue); jump ignored, since the branch is re-evaluated on re-issue.
  3. jump_any==1 -> next=dest_any.
  4. else -> next=pc_mem[t]+1, modulo 2^PC_WIDTH (max value wraps to 0).
- Write and issue: same edge, pc_mem[t]<=next; pc<=next; pc_thread<=t; pc_valid<=1.
- Latency: one clock from slot/inputs to pc outputs.
- Only pc_mem[slot] is written per cycle; other threads are untouched.
- Outputs at reset: pc=0, pc_thread=0, pc_valid=0.
- First edge after reset release: pc=START_PC, pc_thread=INITIAL_THREAD, pc_valid=1.
- Reset asserted mid-operation: all state returns immediately (async) to reset values. In-flight decisions are discarded. All threads restart at START_PC.
- X on IO_ready is treated as not-ready (re-issue).

Optional Feature:
- Macro: THREAD_PC_CONTROLLER_HALT_EN.
- Enabled:
  - Adds input `thread_halt` [THREAD_COUNT].
  - When thread_halt[slot]==1: pc_mem and started are unchanged for that slot. pc_valid<=0 and pc<=pc_mem[slot].
  - On un-halt, the first slot re-issues pc_mem[t] unchanged; inputs are ignored for that slot.
  - Adds 1 bit per thread ("resume") to implement this.
- Disabled: no port, no extra state; pc_valid is 1 in every cycle after the first post-reset edge.

Test Plan:
- Reset release, IO_ready=1, no jumps -> first 8 issues are pc=0 for threads 0..7, pc_valid=1. Next 8 are pc=1, then pc=2.
- Thread 3 at pc=0x3FF, no jump -> its next issue is pc=0x000 (wrap). Other threads unaffected.
- jump_bus=4'b0100 with instance 2 dest=0x155 in thread 5's slot -> thread 5 next issues 0x155, then 0x156.
- IO_ready=0 in thread 2's slot while jump_bus=4'b0001 (dest 0x080) -> thread 2 re-issues same pc; jump ignored. Next slot with IO_ready=1 and no jump -> pc+1.
- jump_bus=4'b0011, dests 0x0F0 and 0x00F -> issued pc=0x0FF.
- Async reset pulse mid-stream (thread 6 at pc 0x020) -> outputs 0/0/0 immediately. After release, all threads re-issue START_PC starting at INITIAL_THREAD.

Source files
------------

// File: rtl/thread_pc_controller.sv
// thread_pc_controller: per-thread program counter sequencer for a barrel-style
// round-robin core. Each cycle it serves the thread in the current slot: it
// OR-reduces the branch-check outputs, applies I/O re-issue, writes the chosen
// next PC back into that thread's entry and issues it to instruction fetch.
//
// Optional feature: define THREAD_PC_CONTROLLER_HALT_EN to add the
// thread_halt port. A halted slot issues a bubble (pc_valid=0) and leaves
// the thread's state untouched. The thread's first slot after un-halt
// re-issues its held PC.
//
// Ports:
//   clock                  system clock
//   reset                  asynchronous, active-high reset
//   branch_destination_bus per-instance destinations, instance i at [i*PC_WIDTH +: PC_WIDTH]
//   jump_bus               per-instance jump decisions
//   IO_ready               low (or X) = previous instruction annulled, re-issue
//   thread_halt            per-thread halt (HALT_EN builds only)
//   pc / pc_thread / pc_valid  registered issue to instruction fetch
module thread_pc_controller #(
  parameter int unsigned PC_WIDTH          = 10,
  parameter int unsigned THREAD_COUNT      = 8,
  parameter int unsigned THREAD_ADDR_WIDTH = 3,
  parameter int unsigned BRANCH_COUNT      = 4,
  parameter int unsigned INITIAL_THREAD    = 0,
  parameter int unsigned START_PC          = 0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [BRANCH_COUNT*PC_WIDTH-1:0] branch_destination_bus,
  input  logic [BRANCH_COUNT-1:0]          jump_bus,
  input  logic                             IO_ready,
`ifdef THREAD_PC_CONTROLLER_HALT_EN
  input  logic [THREAD_COUNT-1:0]          thread_halt,
`endif
  output logic [PC_WIDTH-1:0]              pc,
  output logic [THREAD_ADDR_WIDTH-1:0]     pc_thread,
  output logic                             pc_valid
);

  localparam logic [PC_WIDTH-1:0]          START_PC_V = PC_WIDTH'(START_PC);
  localparam logic [THREAD_ADDR_WIDTH-1:0] INIT_SLOT  = THREAD_ADDR_WIDTH'(INITIAL_THREAD);
  localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_SLOT  = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);

  logic [THREAD_ADDR_WIDTH-1:0] slot_q, slot_d;
  logic [PC_WIDTH-1:0]          pc_mem_q [THREAD_COUNT];
  logic [THREAD_COUNT-1:0]      started_q;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic [THREAD_ADDR_WIDTH-1:0] pc_thread_q;
  logic                         pc_valid_q, pc_valid_d;
  logic                         mem_we;
  logic                         jump_any;
  logic [PC_WIDTH-1:0]          dest_any;
  logic [PC_WIDTH-1:0]          cur_pc;
`ifdef THREAD_PC_CONTROLLER_HALT_EN
  logic [THREAD_COUNT-1:0]      resume_q, resume_d;
`endif

  // Free-running round-robin slot counter.
  always_comb begin
    slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + THREAD_ADDR_WIDTH'(1);
  end

  // Branch reduction: non-jumping instances drive zero, so a plain OR suffices.
  always_comb begin
    jump_any = |jump_bus;
    dest_any = '0;
    for (int unsigned i = 0; i < BRANCH_COUNT; i++) begin
      dest_any = dest_any | branch_destination_bus[i*PC_WIDTH +: PC_WIDTH];
    end
  end

  // Next-PC selection for the thread in the current slot.
  always_comb begin
    cur_pc     = pc_mem_q[slot_q];
    pc_d       = cur_pc;
    pc_valid_d = 1'b1;
    mem_we     = 1'b1;
`ifdef THREAD_PC_CONTROLLER_HALT_EN
    resume_d = resume_q;
    if (thread_halt[slot_q]) begin
      // Bubble: hold state, remember to re-issue the held PC on un-halt.
      pc_valid_d       = 1'b0;
      mem_we           = 1'b0;
      resume_d[slot_q] = 1'b1;
    end else begin
      resume_d[slot_q] = 1'b0;
      if (!started_q[slot_q]) begin
        pc_d = START_PC_V;
      end else if (resume_q[slot_q]) begin
        pc_d = cur_pc;
      end else if (IO_ready) begin
        pc_d = jump_any ? dest_any : cur_pc + PC_WIDTH'(1);
      end else begin
        pc_d = cur_pc;
      end
    end
`else
    if (!started_q[slot_q]) begin
      pc_d = START_PC_V;
    end else if (IO_ready) begin
      // Written as a positive test so an X on IO_ready falls to re-issue.
      pc_d = jump_any ? dest_any : cur_pc + PC_WIDTH'(1);
    end else begin
      pc_d = cur_pc;
    end
`endif
  end

  // State and issue registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q      <= INIT_SLOT;
      started_q   <= '0;
      pc_q        <= '0;
      pc_thread_q <= '0;
      pc_valid_q  <= 1'b0;
      for (int unsigned t = 0; t < THREAD_COUNT; t++) begin
        pc_mem_q[t] <= START_PC_V;
      end
`ifdef THREAD_PC_CONTROLLER_HALT_EN
      resume_q <= '0;
`endif
    end else begin
      slot_q      <= slot_d;
      pc_q        <= pc_d;
      pc_thread_q <= slot_q;
      pc_valid_q  <= pc_valid_d;
      if (mem_we) begin
        pc_mem_q[slot_q]  <= pc_d;
        started_q[slot_q] <= 1'b1;
      end
`ifdef THREAD_PC_CONTROLLER_HALT_EN
      resume_q <= resume_d;
`endif
    end
  end

  assign pc        = pc_q;
  assign pc_thread = pc_thread_q;
  assign pc_valid  = pc_valid_q;

endmodule
